// File: rtl/row_clear_engine.sv
// rtl/row_clear_engine.sv - sequential full-row detector and compactor for the playfield bitmap
module row_clear_engine #(
    parameter int ROWS       = 20,
    parameter int COLS       = 10,
    parameter int SPAWN_ROWS = 2,
    localparam int CW        = $clog2(ROWS + 1)
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 start,
    input  logic [ROWS*COLS-1:0] board_in,
    output logic [ROWS*COLS-1:0] board_out,
    output logic [CW-1:0]        lines_cleared,
    output logic [ROWS-1:0]      cleared_mask,
    output logic                 game_over,
    output logic                 busy,
    output logic                 done
);

    localparam int N  = ROWS * COLS;
    localparam int PW = $clog2(ROWS + 1);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t          state;
    logic [N-1:0]    src;
    logic [N-1:0]    dst;
    logic [N-1:0]    dst_nxt;
    logic [PW-1:0]   rd;
    logic [PW-1:0]   wr;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_nxt;
    logic [ROWS-1:0] mask;
    logic [ROWS-1:0] mask_nxt;
    logic [COLS-1:0] cur_row;
    logic            row_full;
    logic            top_out_nxt;

    // Next-state of the accumulators, so the last SCAN row lands in the published results.
    always_comb begin
        cur_row  = src[int'(rd)*COLS +: COLS];
        row_full = &cur_row;
        dst_nxt  = dst;
        cnt_nxt  = cnt;
        mask_nxt = mask;
        if (row_full) begin
            mask_nxt[rd] = 1'b1;
            cnt_nxt      = cnt + 1'b1;
        end else begin
            dst_nxt[int'(wr)*COLS +: COLS] = cur_row;
        end
        top_out_nxt = |dst_nxt[N-1 -: SPAWN_ROWS*COLS];
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state         <= IDLE;
            src           <= '0;
            dst           <= '0;
            rd            <= '0;
            wr            <= '0;
            cnt           <= '0;
            mask          <= '0;
            board_out     <= '0;
            lines_cleared <= '0;
            cleared_mask  <= '0;
            game_over     <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        src   <= board_in;
                        dst   <= '0;
                        rd    <= '0;
                        wr    <= '0;
                        cnt   <= '0;
                        mask  <= '0;
                        busy  <= 1'b1;
                        state <= SCAN;
                    end
                end
                SCAN: begin
                    dst  <= dst_nxt;
                    cnt  <= cnt_nxt;
                    mask <= mask_nxt;
                    rd   <= rd + 1'b1;
                    if (!row_full) begin
                        wr <= wr + 1'b1;
                    end
                    // Results are registered on the final scan edge so they are valid with done.
                    if (rd == PW'(ROWS - 1)) begin
                        board_out     <= dst_nxt;
                        lines_cleared <= cnt_nxt;
                        cleared_mask  <= mask_nxt;
                        game_over     <= top_out_nxt;
                        done          <= 1'b1;
                        state         <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_row_clear_engine.sv
// tb/tb_row_clear_engine.sv - randomized self-checking bench for row_clear_engine
module tb_row_clear_engine;

    localparam int ROWS  = 20;
    localparam int COLS  = 10;
    localparam int SPAWN = 2;
    localparam int N     = ROWS * COLS;
    localparam int SR    = 4;
    localparam int SC    = 4;
    localparam int SN    = SR * SC;

    logic          clk = 1'b0;
    logic          Reset;
    logic          start;
    logic [N-1:0]  board_in;
    logic [N-1:0]  board_out;
    logic [4:0]    lines_cleared;
    logic [ROWS-1:0] cleared_mask;
    logic          game_over;
    logic          busy;
    logic          done;

    logic          s_start;
    logic [SN-1:0] s_board_in;
    logic [SN-1:0] s_board_out;
    logic [2:0]    s_lines_cleared;
    logic [SR-1:0] s_cleared_mask;
    logic          s_game_over;
    logic          s_busy;
    logic          s_done;

    int n_checks = 0;
    int n_pass   = 0;
    logic [N-1:0] prev_board;

    row_clear_engine #(.ROWS(ROWS), .COLS(COLS), .SPAWN_ROWS(SPAWN)) u_big (
        .Clk(clk), .Reset(Reset), .start(start), .board_in(board_in),
        .board_out(board_out), .lines_cleared(lines_cleared), .cleared_mask(cleared_mask),
        .game_over(game_over), .busy(busy), .done(done)
    );

    row_clear_engine #(.ROWS(SR), .COLS(SC), .SPAWN_ROWS(1)) u_small (
        .Clk(clk), .Reset(Reset), .start(s_start), .board_in(s_board_in),
        .board_out(s_board_out), .lines_cleared(s_lines_cleared), .cleared_mask(s_cleared_mask),
        .game_over(s_game_over), .busy(s_busy), .done(s_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Reference: keep non-full rows in order from row 0 upward, count and mark the full ones.
    task automatic run_big(input logic [N-1:0] b, input int extra_at);
        logic [N-1:0]    eb;
        logic [4:0]      ec;
        logic [ROWS-1:0] em;
        logic            eg;
        logic [COLS-1:0] row;
        logic [COLS-1:0] surv[$];
        int              dones;
        eb = '0; ec = '0; em = '0;
        for (int r = 0; r < ROWS; r++) begin
            row = b[r*COLS +: COLS];
            if (row == {COLS{1'b1}}) begin
                em[r] = 1'b1;
                ec++;
            end else begin
                surv.push_back(row);
            end
        end
        foreach (surv[i]) eb[i*COLS +: COLS] = surv[i];
        eg = |eb[N-1 -: SPAWN*COLS];

        @(negedge clk); board_in = b; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        check("busy_rise", busy, 1);
        dones = 0;
        for (int k = 1; k <= ROWS + 4; k++) begin
            @(posedge clk); #1;
            start = (k == extra_at - 1);
            if (k == 2) check("hold_during_scan", board_out, prev_board);
            if (done) begin
                dones++;
                if (dones == 1) begin
                    check("latency", k + 1, ROWS + 1);
                    check("board_out", board_out, eb);
                    check("lines_cleared", lines_cleared, ec);
                    check("cleared_mask", cleared_mask, em);
                    check("game_over", game_over, eg);
                    check("busy_with_done", busy, 1);
                end
            end
        end
        start = 1'b0;
        check("done_pulses", dones, 1);
        check("busy_idle", busy, 0);
        prev_board = eb;
    endtask

    task automatic run_small(input logic [SN-1:0] b);
        logic [SN-1:0]   eb;
        logic [2:0]      ec;
        logic [SR-1:0]   em;
        logic [SC-1:0]   row;
        logic [SC-1:0]   surv[$];
        int              dones;
        eb = '0; ec = '0; em = '0;
        for (int r = 0; r < SR; r++) begin
            row = b[r*SC +: SC];
            if (row == {SC{1'b1}}) begin
                em[r] = 1'b1;
                ec++;
            end else begin
                surv.push_back(row);
            end
        end
        foreach (surv[i]) eb[i*SC +: SC] = surv[i];

        @(negedge clk); s_board_in = b; s_start = 1'b1;
        @(posedge clk); #1 s_start = 1'b0;
        dones = 0;
        for (int k = 1; k <= SR + 4; k++) begin
            @(posedge clk); #1;
            if (s_done) begin
                dones++;
                if (dones == 1) begin
                    check("s_latency", k + 1, SR + 1);
                    check("s_board_out", s_board_out, eb);
                    check("s_lines_cleared", s_lines_cleared, ec);
                    check("s_cleared_mask", s_cleared_mask, em);
                    check("s_game_over", s_game_over, |eb[SN-1 -: SC]);
                end
            end
        end
        check("s_done_pulses", dones, 1);
    endtask

    function automatic logic [N-1:0] rand_board();
        logic [N-1:0] b;
        b = '0;
        for (int r = 0; r < ROWS; r++) begin
            case ($urandom_range(0, 3))
                0: b[r*COLS +: COLS] = {COLS{1'b1}};
                1: b[r*COLS +: COLS] = '0;
                default: b[r*COLS +: COLS] = COLS'($urandom);
            endcase
        end
        return b;
    endfunction

    initial begin
        logic [N-1:0] b1;
        logic [N-1:0] b;
        logic [SN-1:0] sb;
        int dones;
        Reset = 1'b1; start = 1'b0; board_in = '0; s_start = 1'b0; s_board_in = '0;
        prev_board = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_board_out", board_out, 0);
        check("rst_lines", lines_cleared, 0);
        check("rst_mask", cleared_mask, 0);
        check("rst_game_over", game_over, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        Reset = 1'b0;

        b1 = {180'd0, 10'b0100110010, 10'b1111111111};
        run_big(b1, 0);
        check("t1_board_const", board_out, {190'd0, 10'b0100110010});

        b = '0; b[5*COLS +: COLS] = '1; b[2*COLS +: COLS] = 10'b0000000001;
        run_big(b, 0);
        check("t2_mask_const", cleared_mask, 20'h00020);
        run_big('0, 0);

        b = '0; b[0 +: 4*COLS] = '1; b[4*COLS +: COLS] = 10'b1000000001;
        run_big(b, 0);
        check("t3_board_const", board_out, {190'd0, 10'b1000000001});

        b = '1;
        run_big(b, 3);
        check("t4_lines_const", lines_cleared, 20);

        // Reset mid-scan abandons the pass.
        @(negedge clk); board_in = b1; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (5) @(posedge clk);
        #1 Reset = 1'b1;
        @(posedge clk); #1;
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_board", board_out, 0);
        check("midrst_lines", lines_cleared, 0);
        check("midrst_mask", cleared_mask, 0);
        check("midrst_go", game_over, 0);
        Reset = 1'b0;
        dones = 0;
        repeat (ROWS + 3) begin
            @(posedge clk); #1;
            if (done) dones++;
        end
        check("midrst_no_done", dones, 0);
        prev_board = '0;
        run_big(b1, 0);

        b = '0; b[19*COLS +: COLS] = 10'b0000010000;
        run_big(b, 0);
        check("t6_game_over_const", game_over, 1);

        for (int i = 0; i < 25; i++) run_big(rand_board(), (i % 5 == 0) ? 2 + (i % 7) : 0);

        run_small(16'h8F3F);
        check("s_board_const", s_board_out, 16'h0083);
        check("s_mask_const", s_cleared_mask, 4'b0101);
        for (int i = 0; i < 10; i++) begin
            sb = SN'($urandom);
            if (i % 2 == 0) sb[SC +: SC] = '1;
            run_small(sb);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/row_clear_engine.md
Name: row_clear_engine

Overview:
Parametrised, sequential full-row detector and compactor for the playfield bitmap. On a start pulse it captures a ROWS x COLS occupancy board and scans one row per cycle from the bottom up. Full rows are dropped and non-full rows are compacted downward. It reports the compacted board, the count and mask of cleared rows, and a top-out flag, with a one-cycle done pulse. It sits between the piece-lock logic and the score/board registers and generalises the fixed 20x10 row checker.

Parameters:
ROWS, 20, number of board rows; row 0 is the bottom row.
COLS, 10, cells per row.
SPAWN_ROWS, 2, number of topmost rows checked for top-out after compaction (1..ROWS).

Ports:
Clk  input  1  system clock; all logic on the rising edge.
Reset  input  1  synchronous, active-high reset.
start  input  1  request a clear pass; sampled only in IDLE.
board_in  input  ROWS*COLS  board; row r = bits [r*COLS+COLS-1 : r*COLS]; bit set = occupied.
board_out  output  ROWS*COLS  compacted board, same packing; registered.
lines_cleared  output  CW  number of full rows removed, CW = $clog2(ROWS+1) (5 at defaults).
cleared_mask  output  ROWS  bit r set if input row r was full.
game_over  output  1  any occupied cell in rows ROWS-SPAWN_ROWS..ROWS-1 of board_out.
busy  output  1  pass in progress.
done  output  1  one-cycle pulse; results valid from this cycle.

Behaviour:
- Reset (any state, including mid-pass): FSM returns to IDLE next edge. board_out=0, lines_cleared=0, cleared_mask=0, game_over=0, busy=0, done=0. Internal pointers are cleared. The pass is abandoned with no partial results.
- FSM states: IDLE, SCAN, DONE.
- IDLE: when start=1 at edge T:
  - capture board_in into src;
  - clear the work buffer dst to all-zero;
  - set rd=0, wr=0, clear the count and mask accumulators;
  - go to SCAN.
  - busy rises at T+1.
- SCAN: one row per cycle, row src[rd].
  - If the row is all ones, set mask bit rd and increment the count. wr is unchanged.
  - Otherwise write the row to dst row wr and increment wr.
  - rd increments every cycle. After processing rd=ROWS-1, go to DONE.
  - The pass takes exactly ROWS SCAN cycles, regardless of board content.
- DONE, one cycle:
  - board_out <= dst, lines_cleared <= count, cleared_mask <= mask.
  - game_over <= OR of the top SPAWN_ROWS rows of dst.
  - done=1, busy=1; next state IDLE.
  - Observed latency: the start edge at T gives done high at T+ROWS+1, with outputs valid in the same cycle.
- Outputs hold their last values until the next DONE or Reset. They do not change during SCAN.
- Rows above the final wr are zero, because dst was cleared at start. Relative order of surviving rows is preserved.
- start while busy (SCAN or DONE) is ignored and not queued. start in the cycle after done is accepted.
- busy and done are never high while the FSM is in IDLE.
- Widths:
  - count saturates naturally at ROWS; CW always holds ROWS.
  - rd and wr are $clog2(ROWS) bits (plus 1 if needed for the terminal compare). wr never exceeds rd.
- Edge cases:
  - COLS=1 and ROWS=1 must elaborate.
  - An all-full board gives board_out=0, lines_cleared=ROWS, mask all ones, game_over=0.

Test Plan:
1. Defaults, board_in={180'd0,10'b0100110010,10'b1111111111}, start pulse at T -> done at T+21; board_out={190'd0,10'b0100110010}; lines_cleared=1; cleared_mask=20'h00001; game_over=0.
2. Non-adjacent full rows, no shifting needed:
   - Setup: board_in all zero except row 5=10'b1111111111 and row 2=10'b0000000001, start.
   - Expected: board_out row0=0, row1=0, row2=10'b0000000001 (row 2 compacts down to row 2 since rows 0,1 were empty? No — see note), cleared_mask=20'h00020, lines_cleared=1.
   - Note: empty rows are not full, so they are kept. Result: row2 stays at 2, row 5 removed, all other rows 0. The bench also checks the all-zero board -> board_out=0, count=0, mask=0.
3. Consecutive full rows with a survivor: rows 0..3 full, row 4=10'b1000000001 -> board_out row0=10'b1000000001, all others 0; lines_cleared=4; cleared_mask=20'h0000F.
4. All 200 bits set -> board_out=0, lines_cleared=20, cleared_mask=20'hFFFFF, game_over=0; a second start while busy (at T+3) produces exactly one done pulse.
5. Reset held 1 cycle at T+6 mid-SCAN -> next cycle busy=0, done=0, all outputs 0, no done pulse afterwards; a new start then completes normally per scenario 1.
6. Top-out: row 19=10'b0000010000, no full rows -> game_over=1, lines_cleared=0. Also instantiate ROWS=4, COLS=4, SPAWN_ROWS=1 with rows {0:F,1:3,2:F,3:8} (hex) -> board_out rows {0:3,1:8,2:0,3:0}, count=2, mask=4'b0101, done at T+5.
